trap_ctrl: RTL and testbench
============================

Name: trap_ctrl

Overview:
- Sequencer for the fetch stage's PC-override inputs: reset-vector hold, interrupt entry and return (mret).
- Drives IF's rst_flag/rst_addr/int_flag/int_addr; saves the interrupted sequential PC and cause.
- Arbitrates NUM_IRQ level-sensitive interrupt requesters onto the single interrupt path.
- Sits beside IF; takes IF's computed next PC (plus_pc) as the return-address source.

Parameters:
- NUM_IRQ, 4, number of interrupt request lines (1..8).
- RST_VEC, 32'h0000_0000, reset vector driven on rst_addr.
- RST_HOLD, 2, cycles rst_flag stays asserted after rst_n release (≥1).
- MTVEC_RST, 32'h0000_0100, reset value of trap vector base.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- irq_req  in  NUM_IRQ  level requests; bit 0 highest priority.
- irq_ack  out  NUM_IRQ  one-hot pulse, one cycle, to the granted requester.
- next_pc  in  32  IF sequential/branch-resolved next PC (plus_pc).
- mret  in  1  decoded return-from-trap. Active LOW.
- gie_wr  in  1  global-interrupt-enable write strobe. Active LOW.
- gie_wdata  in  1  new GIE value.
- mtvec_wr  in  1  trap-base write strobe. Active LOW.
- mtvec_wdata  in  32  new trap base; bits [1:0] ignored, stored as 0.
- rst_flag  out  1  to IF. Active LOW.
- rst_addr  out  32  constant RST_VEC.
- int_flag  out  1  to IF. Active LOW.
- int_addr  out  32  handler or return address.
- mepc  out  32  saved return PC.
- mcause  out  4  {valid, cause[2:0]}.
- in_isr  out  1  high while a handler is executing.

Behaviour:
- All outputs registered on posedge clk; async clear when rst_n=0.
- Reset values:
  - rst_flag=0 (asserted), int_flag=1, int_addr=0, irq_ack=0, mepc=0, mcause=0, in_isr=0.
  - GIE=0, mtvec=MTVEC_RST, state=RST.
- FSM states: RST, RUN, TAKE, ISR, RET.
  - RST: counter loads RST_HOLD-1 at reset and decrements each cycle after rst_n release; rst_flag=0. At count 0 -> RUN, and rst_flag=1 from the next cycle.
  - RUN: when GIE=1 and any irq_req bit is set, latch the lowest-index set bit as cause -> TAKE. Level must be present at the sampling posedge.
  - TAKE: one cycle.
    - int_flag=0, int_addr=mtvec.
    - irq_ack[cause]=1.
    - At the end of the cycle: mepc<=next_pc, mcause<={1,cause}, in_isr<=1 -> ISR.
  - ISR: interrupts masked regardless of GIE, so there is no nesting. mret=0 -> RET.
  - RET: one cycle.
    - int_flag=0, int_addr=mepc.
    - At the end of the cycle: in_isr<=0, mcause[3]<=0 -> RUN.
- Latency: irq sampled at posedge k; int_flag low during cycle k..k+1. IF latches int_addr at negedge; handler PC is visible on pc after posedge k+1.
- mret while not in ISR: ignored.
- Simultaneous events in RUN: irq and mtvec_wr in the same cycle -> the new mtvec is used from the following cycle; TAKE uses the old value.
- Simultaneous events in ISR: mret and pending irq -> RET first; the irq is re-evaluated in RUN the cycle after (tail-chain gap of 1 cycle).
- GIE write in the same cycle irq is sampled: the old GIE governs.
- rst_n low in any state: immediate return to RST, all state cleared, rst_flag asserted asynchronously.
- Deassertion of a request after TAKE has no effect on the committed trap.
- mcause/mepc are held until the next TAKE.

Optional Feature:
- Macro TRAP_VECTORED_EN.
- Defined: in TAKE, int_addr = mtvec + {cause,2'b00} (one 4-byte slot per source).
- Undefined: int_addr = mtvec for every cause; the handler reads mcause.

Decomposition:
- Shared package holds:
  - FSM state encoding (RST=0, RUN=1, TAKE=2, ISR=3, RET=4).
  - Cause width 3 and the mcause valid-bit index.
  - Default RST_VEC and MTVEC_RST constants.
- One sub-module: irq_prio_enc (NUM_IRQ to 1 priority encoder) — combinational; outputs valid + index + one-hot.

Test Plan:
- Reset hold, RST_HOLD=2: release rst_n -> rst_flag low for exactly 2 posedges, then high; rst_addr=32'h0; no int_flag activity.
- Single irq: GIE=1, irq_req=4'b0100, next_pc=32'h40 -> one TAKE cycle with int_flag=0, int_addr=32'h100, irq_ack=4'b0100; then mepc=32'h40, mcause=4'b1010, in_isr=1.
- Priority and masking: irq_req=4'b1010 -> cause 1 granted. In ISR, raise irq 0 -> no int_flag until mret.
- Return: mret=0 in ISR with mepc=32'h40 -> one RET cycle with int_flag=0, int_addr=32'h40; in_isr=0 the next cycle. A pending irq 3 is then taken one cycle later.
- Vectored variant (TRAP_VECTORED_EN), mtvec written to 32'h203 -> stored 32'h200; irq 2 -> int_addr=32'h208.
- Reset mid-operation: assert rst_n low during TAKE -> int_flag=1, rst_flag=0 asynchronously; mepc=0, GIE=0 after release.

Source files
------------

// File: rtl/trap_ctrl_pkg.sv
// Shared constants for the trap sequencer: FSM encoding, cause width and reset vectors.
package trap_ctrl_pkg;

  localparam int CAUSE_W    = 3;
  localparam int MCAUSE_VLD = 3;

  localparam logic [31:0] RST_VEC_DEF   = 32'h0000_0000;
  localparam logic [31:0] MTVEC_RST_DEF = 32'h0000_0100;

  localparam logic [2:0] ST_RST  = 3'd0;
  localparam logic [2:0] ST_RUN  = 3'd1;
  localparam logic [2:0] ST_TAKE = 3'd2;
  localparam logic [2:0] ST_ISR  = 3'd3;
  localparam logic [2:0] ST_RET  = 3'd4;

  typedef logic [CAUSE_W-1:0] cause_t;

endpackage

// File: rtl/trap_ctrl_irq_prio_enc.sv
// Fixed-priority encoder: bit 0 wins; reports valid, binary index and one-hot grant.
module irq_prio_enc
  import trap_ctrl_pkg::*;
#(
  parameter int NUM_IRQ = 4
) (
  input  logic [NUM_IRQ-1:0] req_i,
  output logic               vld_o,
  output cause_t             idx_o,
  output logic [NUM_IRQ-1:0] onehot_o
);

  // Isolate the lowest set bit, then convert it to a binary index.
  always_comb begin
    vld_o    = |req_i;
    onehot_o = req_i & (~req_i + NUM_IRQ'(1));
    idx_o    = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      idx_o = idx_o | (onehot_o[i] ? CAUSE_W'(i) : '0);
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer for the fetch stage: reset hold, interrupt entry and mret return.
// Define TRAP_VECTORED_EN to give each cause its own 4-byte slot above mtvec.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int          NUM_IRQ   = 4,
  parameter logic [31:0] RST_VEC   = RST_VEC_DEF,
  parameter int          RST_HOLD  = 2,
  parameter logic [31:0] MTVEC_RST = MTVEC_RST_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_req,
  output logic [NUM_IRQ-1:0] irq_ack,
  input  logic [31:0]        next_pc,
  input  logic               mret,
  input  logic               gie_wr,
  input  logic               gie_wdata,
  input  logic               mtvec_wr,
  input  logic [31:0]        mtvec_wdata,
  output logic               rst_flag,
  output logic [31:0]        rst_addr,
  output logic               int_flag,
  output logic [31:0]        int_addr,
  output logic [31:0]        mepc,
  output logic [3:0]         mcause,
  output logic               in_isr
);

  logic [2:0]         state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  cause_t             cause_q, cause_d;
  logic               gie_q, gie_d;
  logic [31:0]        mtvec_q, mtvec_d;
  logic               rst_flag_q, rst_flag_d;
  logic               int_flag_q, int_flag_d;
  logic [31:0]        int_addr_q, int_addr_d;
  logic [NUM_IRQ-1:0] irq_ack_q, irq_ack_d;
  logic [31:0]        mepc_q, mepc_d;
  logic [3:0]         mcause_q, mcause_d;
  logic               in_isr_q, in_isr_d;

  logic               enc_vld_s;
  cause_t             enc_idx_s;
  logic [NUM_IRQ-1:0] enc_onehot_s;
  logic [31:0]        vec_addr_s;

  irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_enc (
    .req_i    (irq_req),
    .vld_o    (enc_vld_s),
    .idx_o    (enc_idx_s),
    .onehot_o (enc_onehot_s)
  );

`ifdef TRAP_VECTORED_EN
  assign vec_addr_s = mtvec_q + {27'd0, enc_idx_s, 2'b00};
`else
  assign vec_addr_s = mtvec_q;
`endif

  // Next-state and output decode; int_flag defaults high so every override is a single-cycle pulse.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cause_d    = cause_q;
    rst_flag_d = rst_flag_q;
    int_flag_d = 1'b1;
    int_addr_d = int_addr_q;
    irq_ack_d  = '0;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    in_isr_d   = in_isr_q;
    if (!gie_wr) gie_d = gie_wdata;
    else         gie_d = gie_q;
    if (!mtvec_wr) mtvec_d = {mtvec_wdata[31:2], 2'b00};
    else           mtvec_d = mtvec_q;
    case (state_q)
      ST_RST: begin
        if (cnt_q == 8'd0) begin
          state_d    = ST_RUN;
          rst_flag_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_RUN: begin
        if (gie_q && enc_vld_s) begin
          state_d    = ST_TAKE;
          cause_d    = enc_idx_s;
          int_flag_d = 1'b0;
          int_addr_d = vec_addr_s;
          irq_ack_d  = enc_onehot_s;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_TAKE: begin
        state_d  = ST_ISR;
        mepc_d   = next_pc;
        mcause_d = {1'b1, cause_q};
        in_isr_d = 1'b1;
      end
      // Requests stay masked here, so a pending irq waits until RUN after the return.
      ST_ISR: begin
        if (!mret) begin
          state_d    = ST_RET;
          int_flag_d = 1'b0;
          int_addr_d = mepc_q;
        end else begin
          state_d = ST_ISR;
        end
      end
      ST_RET: begin
        state_d              = ST_RUN;
        in_isr_d             = 1'b0;
        mcause_d[MCAUSE_VLD] = 1'b0;
      end
      default: begin
        state_d    = ST_RST;
        cnt_d      = 8'(RST_HOLD - 1);
        rst_flag_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RST;
      cnt_q      <= 8'(RST_HOLD - 1);
      cause_q    <= '0;
      gie_q      <= 1'b0;
      mtvec_q    <= MTVEC_RST;
      rst_flag_q <= 1'b0;
      int_flag_q <= 1'b1;
      int_addr_q <= 32'h0000_0000;
      irq_ack_q  <= '0;
      mepc_q     <= 32'h0000_0000;
      mcause_q   <= 4'h0;
      in_isr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cause_q    <= cause_d;
      gie_q      <= gie_d;
      mtvec_q    <= mtvec_d;
      rst_flag_q <= rst_flag_d;
      int_flag_q <= int_flag_d;
      int_addr_q <= int_addr_d;
      irq_ack_q  <= irq_ack_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      in_isr_q   <= in_isr_d;
    end
  end

  assign rst_flag = rst_flag_q;
  assign rst_addr = RST_VEC;
  assign int_flag = int_flag_q;
  assign int_addr = int_addr_q;
  assign irq_ack  = irq_ack_q;
  assign mepc     = mepc_q;
  assign mcause   = mcause_q;
  assign in_isr   = in_isr_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: expected override pulses are queued, a negedge monitor checks them.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  irq_req;
  logic [3:0]  irq_ack;
  logic [31:0] next_pc;
  logic        mret, gie_wr, gie_wdata, mtvec_wr;
  logic [31:0] mtvec_wdata;
  logic        rst_flag, int_flag, in_isr;
  logic [31:0] rst_addr, int_addr, mepc;
  logic [3:0]  mcause;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  ack;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  trap_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .irq_req     (irq_req),
    .irq_ack     (irq_ack),
    .next_pc     (next_pc),
    .mret        (mret),
    .gie_wr      (gie_wr),
    .gie_wdata   (gie_wdata),
    .mtvec_wr    (mtvec_wr),
    .mtvec_wdata (mtvec_wdata),
    .rst_flag    (rst_flag),
    .rst_addr    (rst_addr),
    .int_flag    (int_flag),
    .int_addr    (int_addr),
    .mepc        (mepc),
    .mcause      (mcause),
    .in_isr      (in_isr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] vec(input logic [31:0] base, input int cause);
`ifdef TRAP_VECTORED_EN
    return base + 32'(cause * 4);
`else
    return base;
`endif
  endfunction

  task automatic push(input logic [31:0] addr, input logic [3:0] ack);
    exp_t e;
    e.addr = addr;
    e.ack  = ack;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Every low cycle of int_flag must consume exactly one queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && int_flag !== 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_int_flag", {31'd0, int_flag}, 32'd1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("int_addr", int_addr, e.addr);
        chk("irq_ack", {28'd0, irq_ack}, {28'd0, e.ack});
      end
    end
  end

  initial begin
    rst_n = 1'b0; irq_req = 4'b0000; next_pc = 32'h0;
    mret = 1'b1; gie_wr = 1'b1; gie_wdata = 1'b0;
    mtvec_wr = 1'b1; mtvec_wdata = 32'h0;
    #12;
    chk("rst_flag_in_reset", {31'd0, rst_flag}, 32'd0);
    chk("int_flag_in_reset", {31'd0, int_flag}, 32'd1);
    chk("int_addr_in_reset", int_addr, 32'h0);
    chk("irq_ack_in_reset", {28'd0, irq_ack}, 32'd0);
    chk("mepc_in_reset", mepc, 32'h0);
    chk("mcause_in_reset", {28'd0, mcause}, 32'd0);
    chk("in_isr_in_reset", {31'd0, in_isr}, 32'd0);
    rst_n = 1'b1;
    tick(1);
    chk("rst_flag_hold1", {31'd0, rst_flag}, 32'd0);
    tick(1);
    chk("rst_flag_released", {31'd0, rst_flag}, 32'd1);
    chk("rst_addr", rst_addr, 32'h0);
    // GIE write with irq in the same cycle: old GIE (0) governs; stray mret is ignored
    gie_wr = 1'b0; gie_wdata = 1'b1; irq_req = 4'b0100; mret = 1'b0;
    tick(1);
    gie_wr = 1'b1; mret = 1'b1; next_pc = 32'h40;
    tick(1);
    push(vec(32'h100, 2), 4'b0100);
    irq_req = 4'b0000;
    tick(1);
    chk("mepc_irq2", mepc, 32'h40);
    chk("mcause_irq2", {28'd0, mcause}, 32'h0000_000a);
    chk("in_isr_irq2", {31'd0, in_isr}, 32'd1);
    chk("irq_ack_after_take", {28'd0, irq_ack}, 32'd0);
    irq_req = 4'b0001;
    tick(2);
    chk("in_isr_masked", {31'd0, in_isr}, 32'd1);
    mret = 1'b0; irq_req = 4'b1000;
    tick(1);
    push(32'h40, 4'b0000);
    mret = 1'b1; next_pc = 32'h80;
    tick(1);
    chk("in_isr_after_ret", {31'd0, in_isr}, 32'd0);
    chk("mcause_after_ret", {28'd0, mcause}, 32'h0000_0002);
    chk("mepc_held", mepc, 32'h40);
    tick(1);
    push(vec(32'h100, 3), 4'b1000);
    irq_req = 4'b0000;
    tick(1);
    chk("mepc_irq3", mepc, 32'h80);
    chk("mcause_irq3", {28'd0, mcause}, 32'h0000_000b);
    mret = 1'b0;
    tick(1);
    push(32'h80, 4'b0000);
    mret = 1'b1;
    tick(1);
    chk("mcause_ret_irq3", {28'd0, mcause}, 32'h0000_0003);
    // Priority 4'b1010 -> cause 1; mtvec written in the same cycle, TAKE uses the old base
    irq_req = 4'b1010; mtvec_wr = 1'b0; mtvec_wdata = 32'h203;
    tick(1);
    push(vec(32'h100, 1), 4'b0010);
    mtvec_wr = 1'b1; irq_req = 4'b0000; next_pc = 32'hc4;
    tick(1);
    chk("mepc_irq1", mepc, 32'hc4);
    chk("mcause_irq1", {28'd0, mcause}, 32'h0000_0009);
    mret = 1'b0;
    tick(1);
    push(32'hc4, 4'b0000);
    mret = 1'b1;
    tick(1);
    irq_req = 4'b0100;
    tick(1);
    push(vec(32'h200, 2), 4'b0100);
    irq_req = 4'b0000;
    tick(1);
    mret = 1'b0;
    tick(1);
    push(32'hc4, 4'b0000);
    mret = 1'b1;
    tick(1);
    irq_req = 4'b0001;
    tick(1);
    push(vec(32'h200, 0), 4'b0001);
    #5;
    rst_n = 1'b0;
    #1;
    chk("int_flag_async_rst", {31'd0, int_flag}, 32'd1);
    chk("rst_flag_async_rst", {31'd0, rst_flag}, 32'd0);
    chk("irq_ack_async_rst", {28'd0, irq_ack}, 32'd0);
    #6;
    rst_n = 1'b1;
    #1;
    chk("mepc_after_rst", mepc, 32'h0);
    chk("mcause_after_rst", {28'd0, mcause}, 32'd0);
    chk("in_isr_after_rst", {31'd0, in_isr}, 32'd0);
    @(posedge clk); #1;
    chk("rst_flag_rehold", {31'd0, rst_flag}, 32'd0);
    tick(1);
    chk("rst_flag_rerelease", {31'd0, rst_flag}, 32'd1);
    // irq 0 still requested: nothing may happen until GIE is set again
    gie_wr = 1'b0; gie_wdata = 1'b1;
    tick(1);
    gie_wr = 1'b1;
    tick(1);
    push(32'h100, 4'b0001);
    irq_req = 4'b0000;
    tick(3);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
